// File: rtl/vram_ctrl.sv
// Single-port pixel store with display-read priority, a small CPU write queue
// and an optional full-screen fill engine (enabled by defining VRAM_FILL_EN).
`timescale 1ns/1ps
module vram_ctrl #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 12,
    parameter int DEPTH      = 307200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              vga_clk,
    input  logic              rst_n,
    input  logic              vga_rdn,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vram_out,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              cpu_ready,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_color,
    output logic              fill_busy
);

    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
    localparam logic [PW:0]     FULL  = (PW+1)'(FIFO_DEPTH);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < LIMIT;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] q_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] q_data_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PW:0]       count_q;
    logic [DATA_W-1:0] vram_out_q;

    logic              push, pop, drain_ok;
    logic              fill_we;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

`ifdef VRAM_FILL_EN
    typedef enum logic {S_IDLE, S_FILL} state_t;
    state_t            state_q;
    logic [ADDR_W-1:0] fill_ptr_q;
    logic [DATA_W-1:0] fill_color_q;
    logic              fill_busy_q;

    // Fill advances only on cycles the display leaves the array free.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            fill_ptr_q   <= '0;
            fill_color_q <= '0;
            fill_busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: if (fill_start) begin
                    state_q      <= S_FILL;
                    fill_ptr_q   <= '0;
                    fill_color_q <= fill_color;
                    fill_busy_q  <= 1'b1;
                end
                S_FILL: if (vga_rdn) begin
                    fill_ptr_q <= fill_ptr_q + ADDR_W'(1);
                    if (fill_ptr_q == ADDR_W'(DEPTH - 1)) begin
                        state_q     <= S_IDLE;
                        fill_busy_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign drain_ok  = (state_q == S_IDLE);
    assign fill_we   = (state_q == S_FILL) && vga_rdn;
    assign fill_addr = fill_ptr_q;
    assign fill_data = fill_color_q;
    assign fill_busy = fill_busy_q;
`else
    logic unused_fill;
    assign unused_fill = ^{fill_start, fill_color};
    assign drain_ok  = 1'b1;
    assign fill_we   = 1'b0;
    assign fill_addr = '0;
    assign fill_data = '0;
    assign fill_busy = 1'b0;
`endif

    assign cpu_ready = (count_q < FULL);
    assign push      = cpu_we && cpu_ready;
    assign pop       = drain_ok && vga_rdn && (count_q != '0);

    always_ff @(posedge vga_clk) begin
        if (push) begin
            q_addr_q[wr_ptr_q] <= cpu_addr;
            q_data_q[wr_ptr_q] <= cpu_data;
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Out-of-range queue entries are still popped, just never written.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = q_addr_q[rd_ptr_q];
        mem_wdata = q_data_q[rd_ptr_q];
        if (fill_we) begin
            mem_we    = 1'b1;
            mem_waddr = fill_addr;
            mem_wdata = fill_data;
        end else if (pop && in_range(q_addr_q[rd_ptr_q])) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (mem_we) mem[mem_waddr[MEM_AW-1:0]] <= mem_wdata;
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            vram_out_q <= '0;
        end else if (!vga_rdn) begin
            vram_out_q <= in_range(vga_addr) ? mem[vga_addr[MEM_AW-1:0]] : '0;
        end
    end

    assign vram_out = vram_out_q;

endmodule

// File: tb/tb_vram_ctrl.sv
// Directed bench for vram_ctrl; fill-engine steps are built only with VRAM_FILL_EN.
`timescale 1ns/1ps
module tb_vram_ctrl;

`ifdef VRAM_FILL_EN
    localparam int TB_DEPTH = 64;
`else
    localparam int TB_DEPTH = 307200;
`endif
    localparam int AW = 19;
    localparam int DW = 12;

    logic          vga_clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          vga_rdn = 1'b1;
    logic [AW-1:0] vga_addr = '0;
    logic [DW-1:0] vram_out;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_data = '0;
    logic          cpu_ready;
    logic          fill_start = 1'b0;
    logic [DW-1:0] fill_color = '0;
    logic          fill_busy;

    int checks = 0;
    int errors = 0;

    vram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(TB_DEPTH), .FIFO_DEPTH(4)) dut (
        .vga_clk(vga_clk), .rst_n(rst_n), .vga_rdn(vga_rdn), .vga_addr(vga_addr),
        .vram_out(vram_out), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_ready(cpu_ready), .fill_start(fill_start), .fill_color(fill_color),
        .fill_busy(fill_busy)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_we = 1'b1;
        cpu_addr = a;
        cpu_data = d;
        step();
        cpu_we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        vga_rdn = 1'b0;
        vga_addr = a;
        step();
        chk(tag, 32'(vram_out), 32'(exp));
        vga_rdn = 1'b1;
    endtask

    initial begin
        int n;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_vram_out", 32'(vram_out), 32'h0);
        chk("rst_cpu_ready", 32'(cpu_ready), 32'h1);
        chk("rst_fill_busy", 32'(fill_busy), 32'h0);
        step();
        step();
        rst_n = 1'b1;

        // basic write then read back
        cpu_write(19'd10, 12'hABC);
        step();
        rd("rd_a10", 19'd10, 12'hABC);
        vga_addr = 19'd0;
        step();
        chk("hold_when_rdn_high", 32'(vram_out), 32'hABC);

        // queue fills while display holds the array
        cpu_write(19'd20, 12'h111);
        cpu_write(19'd24, 12'h444);
        step();
        step();
        vga_rdn = 1'b0;
        vga_addr = 19'd20;
        cpu_write(19'd20, 12'h201);
        chk("ready_after_1", 32'(cpu_ready), 32'h1);
        cpu_write(19'd21, 12'h202);
        cpu_write(19'd22, 12'h203);
        chk("ready_after_3", 32'(cpu_ready), 32'h1);
        cpu_write(19'd23, 12'h204);
        chk("ready_after_4", 32'(cpu_ready), 32'h0);
        chk("no_forward_rd20", 32'(vram_out), 32'h111);
        cpu_write(19'd24, 12'hEEE);
        chk("ready_full_drop", 32'(cpu_ready), 32'h0);
        vga_rdn = 1'b1;
        step();
        chk("ready_after_pop1", 32'(cpu_ready), 32'h1);
        step();
        step();
        step();
        rd("drain_a20", 19'd20, 12'h201);
        rd("drain_a21", 19'd21, 12'h202);
        rd("drain_a22", 19'd22, 12'h203);
        rd("drain_a23", 19'd23, 12'h204);
        rd("dropped_a24", 19'd24, 12'h444);

        // out-of-range read and write
        rd("oor_rd", 19'(TB_DEPTH), 12'h000);
        cpu_write(19'(TB_DEPTH + 5), 12'h777);
        step();
        chk("oor_popped_ready", 32'(cpu_ready), 32'h1);
        rd("pre_oor2", 19'd10, 12'hABC);
        rd("oor_rd2", 19'(TB_DEPTH + 5), 12'h000);

        // reset discards queued writes
        cpu_write(19'd30, 12'h333);
        cpu_write(19'd31, 12'h334);
        step();
        step();
        rd("pre_rst_rd", 19'd10, 12'hABC);
        vga_rdn = 1'b0;
        cpu_write(19'd30, 12'hAAA);
        cpu_write(19'd31, 12'hBBB);
        cpu_write(19'd32, 12'hCCC);
        cpu_write(19'd33, 12'hDDD);
        chk("pre_rst_full", 32'(cpu_ready), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("qrst_vram_out", 32'(vram_out), 32'h0);
        chk("qrst_cpu_ready", 32'(cpu_ready), 32'h1);
        chk("qrst_fill_busy", 32'(fill_busy), 32'h0);
        step();
        rst_n = 1'b1;
        vga_rdn = 1'b1;
        step();
        step();
        rd("qrst_a30", 19'd30, 12'h333);
        rd("qrst_a31", 19'd31, 12'h334);

`ifdef VRAM_FILL_EN
        // full-screen fill with a CPU write landing on top of it
        fill_color = 12'h0F0;
        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        fill_color = 12'hF00;
        chk("fill_busy_rise", 32'(fill_busy), 32'h1);
        n = 1;
        while (fill_busy && n < 4 * TB_DEPTH) begin
            cpu_we = (n == 2);
            cpu_addr = 19'd5;
            cpu_data = 12'h123;
            fill_start = (n == 10);
            step();
            if (fill_busy) n++;
        end
        cpu_we = 1'b0;
        fill_start = 1'b0;
        chk("fill_busy_cycles", 32'(n), 32'(TB_DEPTH));
        step();
        rd("fill_cpu_a5", 19'd5, 12'h123);
        rd("fill_a6", 19'd6, 12'h0F0);
        rd("fill_a0", 19'd0, 12'h0F0);
        rd("fill_last", 19'(TB_DEPTH - 1), 12'h0F0);
        rd("fill_a20", 19'd20, 12'h0F0);

        // reset in the middle of a fill
        cpu_write(19'd40, 12'h401);
        cpu_write(19'd41, 12'h402);
        step();
        step();
        rd("pre_mid_rd", 19'd5, 12'h123);
        fill_color = 12'h555;
        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        step();
        step();
        cpu_write(19'd40, 12'hAAA);
        cpu_write(19'd41, 12'hBBB);
        chk("mid_busy", 32'(fill_busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(fill_busy), 32'h0);
        chk("mid_rst_ready", 32'(cpu_ready), 32'h1);
        chk("mid_rst_vram_out", 32'(vram_out), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("mid_after_busy", 32'(fill_busy), 32'h0);
        rd("mid_a40", 19'd40, 12'h401);
        rd("mid_a41", 19'd41, 12'h402);
        rd("mid_partial_a2", 19'd2, 12'h555);
        rd("mid_untouched_a50", 19'd50, 12'h0F0);
`else
        // fill engine absent: start pulse does nothing
        fill_color = 12'h0F0;
        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        chk("nofill_busy", 32'(fill_busy), 32'h0);
        step();
        step();
        rd("nofill_a10", 19'd10, 12'hABC);
        rd("nofill_a21", 19'd21, 12'h202);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
